// File: rtl/led_scanner.sv
// led_scanner: one-hot LED bar scanner with bounce/rotate/hold modes.
//
// A free-running prescaler produces a registered Tick strobe whose period is
// 2^(DIV_BITS-Speed) cycles. On every tick the lit position steps according to
// Mode. Pause freezes the prescaler and all state.
//
// Ports:
//   Clk     in   1      system clock
//   Rst_n   in   1      asynchronous active-low reset
//   Mode    in   2      step behaviour (see table below)
//   Speed   in   2      step period select, higher is faster
//   Pause   in   1      freeze prescaler and position while high
//   LED     out  WIDTH  LED drive, active high
//   Dir     out  1      0 = moving toward bit 0, 1 = toward bit WIDTH-1
//   Tick    out  1      one-cycle strobe on each step
//   EndHit  out  1      one-cycle pulse when bounce lands on an end bit
//
// Optional feature macro: LED_SCANNER_TRAIL_EN
//   When defined, a Prev register holds the previous position and
//   LED = Pos | Prev (two-LED comet). When undefined, LED = Pos.
//
// Mode | meaning
// -----+------------------------------------------------------
//  00  | bounce between bit 0 and bit WIDTH-1
//  01  | rotate toward bit 0, bit 0 wraps to bit WIDTH-1
//  10  | rotate toward bit WIDTH-1, bit WIDTH-1 wraps to bit 0
//  11  | hold position and direction

module led_scanner #(
  parameter int WIDTH    = 8,
  parameter int DIV_BITS = 24
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [1:0]       Mode,
  input  logic [1:0]       Speed,
  input  logic             Pause,
  output logic [WIDTH-1:0] LED,
  output logic             Dir,
  output logic             Tick,
  output logic             EndHit
);

  localparam logic [1:0] MODE_BOUNCE = 2'b00;
  localparam logic [1:0] MODE_ROT_R  = 2'b01;
  localparam logic [1:0] MODE_ROT_L  = 2'b10;

  localparam logic [WIDTH-1:0]    POS_MSB   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [DIV_BITS-1:0] PRESC_ONE = {{(DIV_BITS-1){1'b0}}, 1'b1};
  localparam logic [DIV_BITS-1:0] ALL_ONES  = '1;

  logic [DIV_BITS-1:0] presc;
  logic [DIV_BITS-1:0] presc_mask;
  logic                tick_now;
  logic [WIDTH-1:0]    pos;
  logic [WIDTH-1:0]    pos_nxt;
  logic                dir_nxt;
  logic                end_nxt;
  logic                recover;

  // Mask selects the low (DIV_BITS-Speed) bits; decoded from Speed every
  // cycle so a speed change lands immediately.
  assign presc_mask = ALL_ONES >> Speed;
  assign tick_now   = ((presc & presc_mask) == presc_mask) && !Pause;
  assign recover    = !$onehot(pos);

  always_comb begin
    pos_nxt = pos;
    dir_nxt = Dir;
    end_nxt = 1'b0;
    if (recover) begin
      pos_nxt = POS_MSB;
      dir_nxt = 1'b0;
    end else begin
      case (Mode)
        MODE_BOUNCE: begin
          // Turn around on the end bit itself so each end dwells one period.
          if (!Dir && pos[0]) begin
            dir_nxt = 1'b1;
            pos_nxt = pos << 1;
          end else if (Dir && pos[WIDTH-1]) begin
            dir_nxt = 1'b0;
            pos_nxt = pos >> 1;
          end else begin
            pos_nxt = Dir ? (pos << 1) : (pos >> 1);
          end
          end_nxt = pos_nxt[0] | pos_nxt[WIDTH-1];
        end
        MODE_ROT_R: begin
          dir_nxt = 1'b0;
          pos_nxt = {pos[0], pos[WIDTH-1:1]};
        end
        MODE_ROT_L: begin
          dir_nxt = 1'b1;
          pos_nxt = {pos[WIDTH-2:0], pos[WIDTH-1]};
        end
        default: begin
          pos_nxt = pos;
          dir_nxt = Dir;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      presc  <= '0;
      Tick   <= 1'b0;
      pos    <= POS_MSB;
      Dir    <= 1'b0;
      EndHit <= 1'b0;
    end else begin
      Tick   <= tick_now;
      EndHit <= 1'b0;
      if (!Pause) begin
        presc <= presc + PRESC_ONE;
      end
      if (tick_now) begin
        pos    <= pos_nxt;
        Dir    <= dir_nxt;
        EndHit <= end_nxt;
      end
    end
  end

`ifdef LED_SCANNER_TRAIL_EN
  logic [WIDTH-1:0] prev;

  // Prev takes the outgoing position on every tick; in hold mode that equals
  // the current position, so the trail collapses after one tick.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prev <= '0;
    end else if (tick_now) begin
      prev <= recover ? '0 : pos;
    end
  end

  assign LED = pos | prev;
`else
  assign LED = pos;
`endif

endmodule

// File: doc/led_scanner.md
Name: led_scanner

Overview:
- Parametrised successor to the single-LED slider. Drives a WIDTH-bit one-hot LED bar from one clock.
- Four modes: bounce, rotate right, rotate left, hold.
- Runtime speed select, pause input, direction and end-of-travel status outputs.
- Sits between the board clock and the LED pins. Status outputs are available to other front-panel logic.

Parameters:
WIDTH, 8, number of LEDs; legal range 2..32.
DIV_BITS, 24, prescaler counter width; legal range 4..32.

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous, active-low reset
Mode  in  2  00 bounce, 01 rotate right (toward bit 0), 10 rotate left (toward bit WIDTH-1), 11 hold
Speed  in  2  step period select; higher value is faster
Pause  in  1  freezes prescaler and position while high
LED  out  WIDTH  LED drive, active high
Dir  out  1  current direction; 0 = toward bit 0, 1 = toward bit WIDTH-1
Tick  out  1  one-cycle strobe on each step instant
EndHit  out  1  one-cycle pulse when bounce mode moves the light onto bit 0 or bit WIDTH-1

Behaviour:
- Clock and reset: one clock, Clk. Reset Rst_n is asynchronous and active-low.
- Reset values:
  - Internal one-hot position Pos = MSB only, so LED = 1 followed by WIDTH-1 zeros.
  - Dir=0, prescaler=0, Tick=0, EndHit=0.
- Prescaler:
  - DIV_BITS-bit counter. Increments every cycle while Pause=0 and holds while Pause=1.
  - Tick is registered. It goes high for one cycle when the low (DIV_BITS-Speed) bits of the counter are all ones and Pause=0.
  - Tick period is 2^(DIV_BITS-Speed) cycles.
  - A Speed change takes effect immediately. The next tick may therefore come early; it is never skipped beyond one full new period.
- Step: Pos, Dir and EndHit update in the same cycle Tick is high, using the Mode, Dir and Pos values from that cycle.
- Mode 00, bounce:
  - Dir=0 and Pos[0]=1: Dir<=1, Pos shifts one place toward the MSB.
  - Dir=1 and Pos[WIDTH-1]=1: Dir<=0, Pos shifts one place toward the LSB.
  - Otherwise Pos shifts one place in direction Dir.
  - Each end is lit for exactly one tick period; there is no double dwell.
  - EndHit=1 on the tick whose new Pos is bit 0 or bit WIDTH-1. Entry into bounce mode itself never pulses EndHit.
- Mode 01: Dir<=0. Pos rotates toward the LSB; bit 0 wraps to bit WIDTH-1. EndHit=0.
- Mode 10: Dir<=1. Pos rotates toward the MSB; bit WIDTH-1 wraps to bit 0. EndHit=0.
- Mode 11: Pos and Dir hold. EndHit=0. Tick still strobes.
- Mode changes mid-run:
  - Applied at the next tick; the position is preserved.
  - Switching back to bounce keeps the last Dir.
- Pause: takes priority over ticking. LED and all state are frozen. The prescaler resumes from its held value on release.
- Recovery: if Pos is ever not one-hot (zero or multi-bit), the next tick reloads Pos to the MSB with Dir=0. This is checked before the mode logic.
- Output mapping: LED = Pos; no combinational path from inputs to LED. Dir and EndHit are registered.
- Reset asserted mid-operation returns every register to its reset value immediately, independent of Clk.

Optional Feature:
- Macro: LED_SCANNER_TRAIL_EN.
- Defined:
  - An extra WIDTH-bit register Prev (reset 0) is loaded with Pos on every tick in which Pos changes. In mode 11 it is loaded with Pos, so the trail collapses after one tick.
  - LED = Pos | Prev, giving a two-LED comet.
  - Recovery reload also clears Prev.
- Undefined: no Prev register; LED = Pos.

Test Plan:
All scenarios use WIDTH=8, DIV_BITS=4 and Speed=3, so Tick occurs every 2 cycles, unless stated.
- Reset release, Mode=00:
  - LED 0x80 -> 0x40 -> ... -> 0x01 -> 0x02 on successive ticks.
  - Dir goes 0->1 on the tick leaving 0x01.
  - EndHit pulses exactly on the ticks that produce 0x01 and 0x80.
- Mode=01 from 0x02 -> 0x01 -> 0x80 -> 0x40, Dir=0, EndHit never high. Mode=10 from 0x40 -> 0x80 -> 0x01, Dir=1.
- Speed=0: 16 cycles between Tick pulses. Switch Speed 0->3 mid-period: the next Tick arrives within 2 cycles, then every 2 cycles.
- Pause high for 10 cycles at LED=0x10: no Tick, LED stays 0x10, prescaler frozen. Release: the next Tick follows at the same prescaler phase.
- Rst_n low asynchronously between clock edges at LED=0x04, Dir=1: LED=0x80, Dir=0, Tick=0 before the next Clk edge.
- With LED_SCANNER_TRAIL_EN, Mode=00 from reset: LED 0x80 -> 0xC0 -> 0x60 -> ... -> 0x03 -> 0x01|0x02 = 0x03. Then Mode=11: LED collapses to a single bit after one tick.
